// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment scan driver: hex font, unlit pattern
// and the digit-index width helper.
package ssd_pkg;

    localparam logic [6:0] SEG_OFF = 7'b0000000;

    // Segment order {a,b,c,d,e,f,g}, 1 = lit.
    localparam logic [6:0] HEX_FONT [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/ssd_scan_driver_if.sv
// Register-side and pin-side signals of the scan driver; the controller
// drives the display request, the driver returns the pin levels.
interface ssd_scan_driver_if #(
    parameter int N_DIGITS = 4,
    parameter int BR_W     = 4
);
    logic                    load;
    logic [4*N_DIGITS-1:0]   data;
    logic [N_DIGITS-1:0]     dp_in;
    logic [N_DIGITS-1:0]     blank_in;
    logic                    lz_en;
    logic [BR_W-1:0]         brightness;
    logic [6:0]              seg;
    logic                    dp;
    logic [N_DIGITS-1:0]     dig_en;
    logic                    frame_start;

    modport master (
        output load, data, dp_in, blank_in, lz_en, brightness,
        input  seg, dp, dig_en, frame_start
    );

    modport slave (
        input  load, data, dp_in, blank_in, lz_en, brightness,
        output seg, dp, dig_en, frame_start
    );
endinterface

// File: rtl/ssd_hex_font.sv
// Combinational hex nibble to {a..g} segment decoder, active-high.
module ssd_hex_font
    import ssd_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg7
);
    assign seg7 = HEX_FONT[nib];
endmodule

// File: rtl/ssd_scan_driver.sv
// Multiplexed seven-segment scan driver with frame-synchronous double
// buffering, leading-zero suppression, PWM dimming and ghost blanking.
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int PRESC_W        = 8,
    parameter int BR_W           = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input logic               clk,
    input logic               rst_n,
    ssd_scan_driver_if.slave  bus
);
    localparam int KW = clog2(N_DIGITS);
    localparam logic [PRESC_W-1:0]  P_MAX    = '1;
    localparam logic [KW-1:0]       K_LAST   = KW'(N_DIGITS - 1);
    localparam logic [6:0]          SEG_IDLE = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
    localparam logic                DP_IDLE  = SEG_ACTIVE_LOW;
    localparam logic [N_DIGITS-1:0] DIG_IDLE = DIG_ACTIVE_LOW ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

    logic [PRESC_W-1:0]    p_p0;
    logic [KW-1:0]         k_p0;
    logic [4*N_DIGITS-1:0] pend_data, act_data;
    logic [N_DIGITS-1:0]   pend_dp, act_dp, pend_blank, act_blank;
    logic                  pend_vld;

    logic [3:0]            nib [N_DIGITS];
    logic [N_DIGITS-1:0]   zero_from;
    logic                  zero_run;
    logic [6:0]            cur_font;
    logic [BR_W-1:0]       t;
    logic                  slot_end, frame_wrap, visible, pwm_on, drive;
    logic [N_DIGITS-1:0]   sel;

    logic [6:0]            seg_p1;
    logic                  dp_p1, fs_p1;
    logic [N_DIGITS-1:0]   dig_p1;

    assign slot_end   = (p_p0 == P_MAX);
    assign frame_wrap = slot_end && (k_p0 == K_LAST);

    // Stage p0: prescaler, scan index and the pending/active buffer pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_p0       <= '0;
            k_p0       <= '0;
            pend_data  <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            pend_vld   <= 1'b0;
            act_data   <= '0;
            act_dp     <= '0;
            act_blank  <= '0;
        end else begin
            p_p0 <= p_p0 + PRESC_W'(1);
            if (slot_end)
                k_p0 <= frame_wrap ? '0 : k_p0 + KW'(1);
            if (bus.load) begin
                pend_data  <= bus.data;
                pend_dp    <= bus.dp_in;
                pend_blank <= bus.blank_in;
            end
            // A load on the wrap cycle queues behind the transfer of older data.
            if (frame_wrap && pend_vld) begin
                act_data  <= pend_data;
                act_dp    <= pend_dp;
                act_blank <= pend_blank;
            end
            if (bus.load)
                pend_vld <= 1'b1;
            else if (frame_wrap)
                pend_vld <= 1'b0;
        end
    end

    always_comb begin
        zero_run  = 1'b1;
        zero_from = '0;
        for (int i = 0; i < N_DIGITS; i++)
            nib[i] = act_data[4*i +: 4];
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_run     = zero_run & (act_data[4*i +: 4] == 4'd0);
            zero_from[i] = zero_run;
        end
    end

    ssd_hex_font u_font (
        .nib  (nib[k_p0]),
        .seg7 (cur_font)
    );

    assign visible = !(act_blank[k_p0] || (bus.lz_en && (k_p0 != '0) && zero_from[k_p0]));
    assign t       = p_p0[PRESC_W-1 -: BR_W];
    assign pwm_on  = (bus.brightness == '1) || (t < bus.brightness);
    assign drive   = pwm_on && (p_p0 != '0) && visible;
    assign sel     = drive ? (N_DIGITS'(1) << k_p0) : '0;

    // Stage p1: registered pins, polarity applied last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_p1 <= SEG_IDLE;
            dp_p1  <= DP_IDLE;
            dig_p1 <= DIG_IDLE;
            fs_p1  <= 1'b0;
        end else begin
            seg_p1 <= (visible ? cur_font : SEG_OFF) ^ SEG_IDLE;
            dp_p1  <= (visible & act_dp[k_p0]) ^ DP_IDLE;
            dig_p1 <= sel ^ DIG_IDLE;
            fs_p1  <= frame_wrap;
        end
    end

    assign bus.seg         = seg_p1;
    assign bus.dp          = dp_p1;
    assign bus.dig_en      = dig_p1;
    assign bus.frame_start = fs_p1;
endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed bench for ssd_scan_driver with 4 digits, 16-cycle slots, 2-bit brightness.
module tb_ssd_scan_driver;
    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ssd_scan_driver_if #(.N_DIGITS(4), .BR_W(2)) bus ();

    ssd_scan_driver #(
        .N_DIGITS (4),
        .PRESC_W  (4),
        .BR_W     (2)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Hand-written glyphs, packed {digit3, digit2, digit1, digit0}.
    localparam logic [27:0] ES_12AF = {7'b0110000, 7'b1101101, 7'b1110111, 7'b1000111};
    localparam logic [27:0] ES_0005 = {7'b1111110, 7'b1111110, 7'b1111110, 7'b1011011};
    localparam logic [27:0] ES_3333 = {4{7'b1111001}};
    localparam logic [27:0] ES_4444 = {4{7'b0110011}};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dpv, input logic [3:0] blk);
        bus.data     = d;
        bus.dp_in    = dpv;
        bus.blank_in = blk;
        bus.load     = 1'b1;
    endtask

    task automatic wait_fs(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.frame_start !== 1'b1 && n < 200);
        chk({tag, "_frame_start"}, 32'(bus.frame_start), 32'd1);
    endtask

    // Called on a frame_start sample; checks the 64 registered cycles that follow.
    task automatic run_frame(input string tag, input logic [27:0] es, input logic [3:0] vis,
                             input logic [3:0] edp, input logic [1:0] br,
                             input int ld_at, input logic [15:0] ldv);
        logic       exp_on;
        logic [6:0] exp_seg;
        logic [3:0] exp_de;
        for (int d = 0; d < 4; d++) begin
            for (int j = 0; j < 16; j++) begin
                @(negedge clk);
                exp_on  = (j != 0) && (br == 2'd3 || (j / 4) < int'(br));
                exp_seg = vis[d] ? es[d*7 +: 7] : 7'b0;
                exp_de  = (vis[d] && exp_on) ? ~(4'b0001 << d) : 4'b1111;
                chk($sformatf("%s_seg_d%0d_p%0d", tag, d, j), 32'(bus.seg), 32'(exp_seg));
                chk($sformatf("%s_dig_d%0d_p%0d", tag, d, j), 32'(bus.dig_en), 32'(exp_de));
                chk($sformatf("%s_dp_d%0d_p%0d", tag, d, j), 32'(bus.dp), 32'(vis[d] & edp[d]));
                if (d*16 + j == ld_at) begin
                    bus.data = ldv;
                    bus.load = 1'b1;
                end else begin
                    bus.load = 1'b0;
                end
            end
        end
        chk({tag, "_next_frame_start"}, 32'(bus.frame_start), 32'd1);
    endtask

    initial begin
        int n;
        rst_n          = 1'b0;
        bus.load       = 1'b0;
        bus.data       = '0;
        bus.dp_in      = '0;
        bus.blank_in   = '0;
        bus.lz_en      = 1'b0;
        bus.brightness = 2'd3;
        repeat (3) @(negedge clk);
        chk("rst_seg", 32'(bus.seg), 32'h00);
        chk("rst_dp", 32'(bus.dp), 32'h0);
        chk("rst_dig_en", 32'(bus.dig_en), 32'hF);
        chk("rst_frame_start", 32'(bus.frame_start), 32'h0);
        rst_n = 1'b1;

        // Basic scan of 12AF.
        do_load(16'h12AF, 4'b0000, 4'b0000);
        @(negedge clk);
        bus.load = 1'b0;
        wait_fs("t1");
        run_frame("t1", ES_12AF, 4'hF, 4'h0, 2'd3, -1, 16'h0);

        // Leading-zero suppression; load at frame start shows one frame later.
        bus.lz_en = 1'b1;
        do_load(16'h0005, 4'b0000, 4'b0000);
        run_frame("t2_old", ES_12AF, 4'hF, 4'h0, 2'd3, -1, 16'h0);
        run_frame("t2_lz", ES_0005, 4'b0001, 4'h0, 2'd3, -1, 16'h0);
        bus.lz_en = 1'b0;
        run_frame("t2_nolz", ES_0005, 4'hF, 4'h0, 2'd3, -1, 16'h0);

        // PWM brightness.
        bus.brightness = 2'd1;
        run_frame("t3_br1", ES_0005, 4'hF, 4'h0, 2'd1, -1, 16'h0);
        bus.brightness = 2'd0;
        run_frame("t3_br0", ES_0005, 4'hF, 4'h0, 2'd0, -1, 16'h0);
        bus.brightness = 2'd3;

        // Double buffering: mid-frame load, then load on the frame_start cycle.
        run_frame("t4_mid", ES_0005, 4'hF, 4'h0, 2'd3, 20, 16'h3333);
        do_load(16'h4444, 4'b0000, 4'b0000);
        run_frame("t4_3333", ES_3333, 4'hF, 4'h0, 2'd3, -1, 16'h0);
        run_frame("t4_4444", ES_4444, 4'hF, 4'h0, 2'd3, -1, 16'h0);

        // Blank mask and decimal points.
        do_load(16'h4444, 4'b0001, 4'b0100);
        run_frame("t5_pend", ES_4444, 4'hF, 4'h0, 2'd3, -1, 16'h0);
        run_frame("t5", ES_4444, 4'b1011, 4'b0001, 2'd3, -1, 16'h0);

        // Asynchronous reset in the middle of digit 0's slot.
        repeat (7) @(negedge clk);
        chk("t6_pre_dig_en", 32'(bus.dig_en), 32'hE);
        chk("t6_pre_dp", 32'(bus.dp), 32'h1);
        chk("t6_pre_seg", 32'(bus.seg), 32'h33);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_seg", 32'(bus.seg), 32'h00);
        chk("t6_rst_dp", 32'(bus.dp), 32'h0);
        chk("t6_rst_dig_en", 32'(bus.dig_en), 32'hF);
        chk("t6_rst_frame_start", 32'(bus.frame_start), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.frame_start !== 1'b1 && n < 200);
        chk("t6_first_frame_cycles", 32'(n), 32'd64);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
